// File: rtl/alien_pkg.sv
// alien_pkg: shared constants for the alien formation march controller.
// Holds coordinate widths, default screen geometry, the march state codes
// and the step-period helper used when ALIEN_MARCH_SPEEDUP_EN is defined.
package alien_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int ADDX_W   = 3;
    localparam int ALIENS_W = 6;

    localparam int unsigned DEF_SCREEN_W        = 160;
    localparam int unsigned DEF_FORMATION_W     = 88;
    localparam int unsigned DEF_STEP_X          = 2;
    localparam int unsigned DEF_STEP_Y          = 4;
    localparam int unsigned DEF_Y_LIMIT         = 80;
    localparam int unsigned DEF_FRAMES_PER_STEP = 16;

    // March state codes
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MARCH  = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;
    localparam logic [1:0] ST_LANDED = 2'd3;

    // Frames per step as the formation thins out; never below one frame.
    function automatic int unsigned march_period(input logic [ALIENS_W-1:0] aliens,
                                                 input int unsigned         base);
        int unsigned p;
        if (aliens >= 6'd32)      p = base;
        else if (aliens >= 6'd16) p = base / 2;
        else if (aliens >= 6'd8)  p = base / 4;
        else if (aliens >= 6'd2)  p = base / 8;
        else                      p = 1;
        if (p < 1) p = 1;
        return p;
    endfunction

endpackage

// File: rtl/alien_march_ctrl_pacer.sv
// march_pacer: counts frame strobes and raises step_req on the frame that
// completes a step period. Optional macro ALIEN_MARCH_SPEEDUP_EN makes the
// period follow aliens_left; otherwise the period is FRAMES_PER_STEP.
module march_pacer
    import alien_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP = DEF_FRAMES_PER_STEP
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                frame_tick,
    input  logic                hold,
    input  logic                clear,
    input  logic [ALIENS_W-1:0] aliens_left,
    output logic                step_req
);

    localparam int unsigned CNT_W = $clog2(FRAMES_PER_STEP + 1);

    logic [CNT_W-1:0] cnt_p0;
    logic [CNT_W-1:0] period;

`ifdef ALIEN_MARCH_SPEEDUP_EN
    logic [CNT_W-1:0] period_p0;

    // Period is latched on restart and on every step, so a shrinking period
    // always takes effect with the counter at zero and can never strand it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            period_p0 <= CNT_W'(FRAMES_PER_STEP);
        else if (clear || step_req)
            period_p0 <= CNT_W'(march_period(aliens_left, FRAMES_PER_STEP));
    end

    assign period = period_p0;
`else
    logic unused_aliens;
    assign unused_aliens = ^aliens_left;
    assign period        = CNT_W'(FRAMES_PER_STEP);
`endif

    // Restart has priority; a held pacer ignores frame strobes entirely.
    assign step_req = frame_tick && !hold && !clear && (cnt_p0 == period - 1'b1);

    // Frame counter: wraps to zero on the step frame, frozen while held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_p0 <= '0;
        else if (clear)
            cnt_p0 <= '0;
        else if (frame_tick && !hold)
            cnt_p0 <= step_req ? '0 : cnt_p0 + 1'b1;
    end

endmodule

// File: rtl/alien_march_ctrl.sv
// alien_march_ctrl: formation-level march controller. Paces steps from the
// frame strobe, walks a shared x offset between the screen edges, drops and
// reverses at each edge, and flags landing at Y_LIMIT.
// Optional macro ALIEN_MARCH_SPEEDUP_EN (in march_pacer) speeds the march up
// as aliens_left falls.
module alien_march_ctrl
    import alien_pkg::*;
#(
    parameter int unsigned SCREEN_W        = DEF_SCREEN_W,
    parameter int unsigned FORMATION_W     = DEF_FORMATION_W,
    parameter int unsigned STEP_X          = DEF_STEP_X,
    parameter int unsigned STEP_Y          = DEF_STEP_Y,
    parameter int unsigned Y_LIMIT         = DEF_Y_LIMIT,
    parameter int unsigned FRAMES_PER_STEP = DEF_FRAMES_PER_STEP
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                frame_tick,
    input  logic                freeze,
    input  logic [ALIENS_W-1:0] aliens_left,
    output logic [ADDX_W-1:0]   add_x,
    output logic                dir_left,
    output logic [X_W-1:0]      x_offset,
    output logic [Y_W-1:0]      y_offset,
    output logic                step_pulse,
    output logic                landed
);

    // Edge and floor tests run in 9 bits so the sums cannot wrap.
    localparam logic [8:0]        SCREEN_W9 = 9'(SCREEN_W);
    localparam logic [8:0]        FORM_W9   = 9'(FORMATION_W);
    localparam logic [8:0]        STEP_X9   = 9'(STEP_X);
    localparam logic [8:0]        STEP_Y9   = 9'(STEP_Y);
    localparam logic [8:0]        Y_LIMIT9  = 9'(Y_LIMIT);
    localparam logic [X_W-1:0]    STEP_XX   = X_W'(STEP_X);
    localparam logic [Y_W-1:0]    STEP_YY   = Y_W'(STEP_Y);
    localparam logic [Y_W-1:0]    Y_LIMITY  = Y_W'(Y_LIMIT);
    localparam logic [ADDX_W-1:0] STEP_ADDX = ADDX_W'(STEP_X);

    logic [1:0]        state_p1;
    logic [X_W-1:0]    x_off_p1;
    logic [Y_W-1:0]    y_off_p1;
    logic              dir_p1;
    logic              landed_p1;
    logic [ADDX_W-1:0] add_x_p1;
    logic              vld_p1;

    logic       step_req;
    logic       pacer_hold;
    logic [8:0] x9;
    logic       can_move;

    // True when the next drop reaches or passes the landing row.
    function automatic logic floor_hit(input logic [Y_W-1:0] y);
        return ({2'b00, y} + STEP_Y9) >= Y_LIMIT9;
    endfunction

    // Next drop offset, saturated at the landing row.
    function automatic logic [Y_W-1:0] drop_sat(input logic [Y_W-1:0] y);
        return floor_hit(y) ? Y_LIMITY : y + STEP_YY;
    endfunction

    assign pacer_hold = (state_p1 != ST_MARCH) || freeze;

    march_pacer #(
        .FRAMES_PER_STEP (FRAMES_PER_STEP)
    ) u_pacer (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_tick  (frame_tick),
        .hold        (pacer_hold),
        .clear       (start),
        .aliens_left (aliens_left),
        .step_req    (step_req)
    );

    // Decide whether this step still fits on screen in the current direction.
    always_comb begin
        x9       = {1'b0, x_off_p1};
        can_move = dir_p1 ? (x9 >= STEP_X9)
                          : ((x9 + STEP_X9 + FORM_W9) <= SCREEN_W9);
    end

    // ---- stage p1: march state and registered step results ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_p1  <= ST_IDLE;
            x_off_p1  <= '0;
            y_off_p1  <= '0;
            dir_p1    <= 1'b0;
            landed_p1 <= 1'b0;
            add_x_p1  <= '0;
            vld_p1    <= 1'b0;
        end else begin
            add_x_p1 <= '0;
            vld_p1   <= 1'b0;
            if (start) begin
                state_p1  <= ST_MARCH;
                x_off_p1  <= '0;
                y_off_p1  <= '0;
                dir_p1    <= 1'b0;
                landed_p1 <= 1'b0;
            end else begin
                case (state_p1)
                    ST_MARCH: begin
                        if (freeze) begin
                            state_p1 <= ST_HOLD;
                        end else if (step_req) begin
                            vld_p1 <= 1'b1;
                            if (can_move) begin
                                x_off_p1 <= dir_p1 ? x_off_p1 - STEP_XX : x_off_p1 + STEP_XX;
                                add_x_p1 <= STEP_ADDX;
                            end else begin
                                dir_p1   <= ~dir_p1;
                                y_off_p1 <= drop_sat(y_off_p1);
                                if (floor_hit(y_off_p1)) begin
                                    landed_p1 <= 1'b1;
                                    state_p1  <= ST_LANDED;
                                end
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (!freeze)
                            state_p1 <= ST_MARCH;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign add_x      = add_x_p1;
    assign dir_left   = dir_p1;
    assign x_offset   = x_off_p1;
    assign y_offset   = y_off_p1;
    assign step_pulse = vld_p1;
    assign landed     = landed_p1;

endmodule

// File: tb/tb_alien_march_ctrl.sv
// tb_alien_march_ctrl: directed scenarios plus randomized traffic, with every
// cycle compared against a behavioural model of the march rules.
module tb_alien_march_ctrl;

    localparam int SW  = 160;
    localparam int FW  = 88;
    localparam int SX  = 2;
    localparam int SY  = 4;
    localparam int YL  = 80;
    localparam int FPS = 16;

    localparam int MD_IDLE   = 0;
    localparam int MD_MARCH  = 1;
    localparam int MD_HOLD   = 2;
    localparam int MD_LANDED = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       frame_tick;
    logic       freeze;
    logic [5:0] aliens_left;
    logic [2:0] add_x;
    logic       dir_left;
    logic [7:0] x_offset;
    logic [6:0] y_offset;
    logic       step_pulse;
    logic       landed;

    int n_checks = 0;
    int n_pass   = 0;

    // behavioural model
    int m_mode, m_x, m_y, m_dir, m_landed, m_cnt, m_per, e_pulse, e_addx;

    always #5 clk = ~clk;

    alien_march_ctrl #(
        .SCREEN_W        (SW),
        .FORMATION_W     (FW),
        .STEP_X          (SX),
        .STEP_Y          (SY),
        .Y_LIMIT         (YL),
        .FRAMES_PER_STEP (FPS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .frame_tick  (frame_tick),
        .freeze      (freeze),
        .aliens_left (aliens_left),
        .add_x       (add_x),
        .dir_left    (dir_left),
        .x_offset    (x_offset),
        .y_offset    (y_offset),
        .step_pulse  (step_pulse),
        .landed      (landed)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int model_period(input int al);
`ifdef ALIEN_MARCH_SPEEDUP_EN
        int p;
        p = (al >= 32) ? FPS : (al >= 16) ? FPS / 2 : (al >= 8) ? FPS / 4 :
            (al >= 2) ? FPS / 8 : 1;
        return (p < 1) ? 1 : p;
`else
        return (al < 0) ? FPS : FPS;
`endif
    endfunction

    task automatic model_reset();
        m_mode = MD_IDLE; m_x = 0; m_y = 0; m_dir = 0; m_landed = 0;
        m_cnt = 0; m_per = FPS; e_pulse = 0; e_addx = 0;
    endtask

    // One formation step using screen-space rules on plain integers.
    task automatic model_do_step();
        int max_x;
        int nx;
        max_x   = SW - FW;
        nx      = (m_dir == 0) ? m_x + SX : m_x - SX;
        e_pulse = 1;
        if (nx >= 0 && nx <= max_x) begin
            m_x    = nx;
            e_addx = SX;
        end else begin
            m_dir = 1 - m_dir;
            m_y   = (m_y + SY > YL) ? YL : m_y + SY;
            if (m_y == YL) begin
                m_landed = 1;
                m_mode   = MD_LANDED;
            end
        end
    endtask

    task automatic model_clock(input bit st, input bit tk, input bit fz, input int al);
        e_pulse = 0;
        e_addx  = 0;
        if (st) begin
            m_mode = MD_MARCH; m_x = 0; m_y = 0; m_dir = 0; m_landed = 0;
            m_cnt = 0; m_per = model_period(al);
        end else if (m_mode == MD_MARCH) begin
            if (fz) m_mode = MD_HOLD;
            else if (tk) begin
                m_cnt++;
                if (m_cnt == m_per) begin
                    m_cnt = 0;
                    m_per = model_period(al);
                    model_do_step();
                end
            end
        end else if (m_mode == MD_HOLD) begin
            if (!fz) m_mode = MD_MARCH;
        end
    endtask

    function automatic logic [31:0] dut_pack();
        return {11'b0, add_x, dir_left, x_offset, y_offset, step_pulse, landed};
    endfunction

    function automatic logic [31:0] model_pack();
        return {11'b0, 3'(e_addx), 1'(m_dir), 8'(m_x), 7'(m_y), 1'(e_pulse), 1'(m_landed)};
    endfunction

    // Drive one cycle at the falling edge, check all outputs after the rising edge.
    task automatic cyc(input bit st, input bit tk, input bit fz, input logic [5:0] al);
        @(negedge clk);
        start = st; frame_tick = tk; freeze = fz; aliens_left = al;
        model_clock(st, tk, fz, int'(al));
        @(posedge clk);
        #1;
        chk("outs", dut_pack(), model_pack());
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        int guard;
        bit fz_l;

        reset_n = 1'b0; start = 1'b0; frame_tick = 1'b0; freeze = 1'b0; aliens_left = 6'd63;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", dut_pack(), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // march right to the edge, drop, and start back left
        cyc(1, 0, 0, 63);
        for (int s = 1; s <= 38; s++) begin
            for (int t = 0; t < FPS; t++) cyc(0, 1, 0, 63);
            if (s == 1) begin
                chk("step1_pulse", 32'(step_pulse), 32'd1);
                chk("step1_addx",  32'(add_x),      32'd2);
                chk("step1_x",     32'(x_offset),   32'd2);
                chk("step1_dir",   32'(dir_left),   32'd0);
            end
            if (s == 36) chk("step36_x", 32'(x_offset), 32'd72);
            if (s == 37) begin
                chk("edge_pulse", 32'(step_pulse), 32'd1);
                chk("edge_addx",  32'(add_x),      32'd0);
                chk("edge_y",     32'(y_offset),   32'd4);
                chk("edge_dir",   32'(dir_left),   32'd1);
                chk("edge_x",     32'(x_offset),   32'd72);
            end
            if (s == 38) chk("step38_x", 32'(x_offset), 32'd70);
        end

        // freeze on the completing frame wins; release resumes with counter intact
        for (int t = 0; t < FPS - 1; t++) cyc(0, 1, 0, 63);
        cyc(0, 1, 1, 63);
        chk("frz_nostep", 32'(step_pulse), 32'd0);
        cyc(0, 0, 0, 63);
        cyc(0, 1, 0, 63);
        chk("frz_resume", 32'(step_pulse), 32'd1);
        chk("frz_x",      32'(x_offset),   32'd68);

        // randomized traffic
        fz_l = 1'b0;
        cyc(1, 0, 0, 63);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) fz_l = ~fz_l;
            cyc(($urandom_range(0, 499) == 0), 1'($urandom_range(0, 1)), fz_l,
                6'($urandom_range(0, 63)));
        end

        // march all the way down to the landing row
        cyc(1, 0, 0, 63);
        guard = 0;
        while (!m_landed && guard < 20000) begin
            cyc(0, 1, 0, 63);
            guard++;
        end
        chk("land_flag", 32'(landed),   32'd1);
        chk("land_y",    32'(y_offset), 32'd80);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(0, 1, 0, 63);
            pulses += int'(step_pulse);
        end
        chk("land_quiet", 32'(pulses), 32'd0);
        cyc(1, 0, 0, 63);
        chk("restart_x",      32'(x_offset), 32'd0);
        chk("restart_y",      32'(y_offset), 32'd0);
        chk("restart_landed", 32'(landed),   32'd0);

        // asynchronous reset between clock edges
        for (int i = 0; i < 40; i++) cyc(0, 1, 0, 63);
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_outs", dut_pack(), 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 2 * FPS; i++) begin
            cyc(0, 1, 0, 63);
            pulses += int'(step_pulse);
        end
        chk("idle_after_reset", 32'(pulses), 32'd0);

`ifdef ALIEN_MARCH_SPEEDUP_EN
        cyc(1, 0, 0, 10);
        for (int t = 0; t < 3; t++) begin
            cyc(0, 1, 0, 10);
            chk("spd10_wait", 32'(step_pulse), 32'd0);
        end
        cyc(0, 1, 0, 10);
        chk("spd10_step", 32'(step_pulse), 32'd1);
        cyc(1, 0, 0, 1);
        for (int t = 0; t < 3; t++) begin
            cyc(0, 1, 0, 1);
            chk("spd1_step", 32'(step_pulse), 32'd1);
        end
`endif

        cyc(0, 0, 0, 63);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
